ocm_dp_ram_ctrl: RTL and testbench
==================================

Name: ocm_dp_ram_ctrl

Overview:
- Parametrised true-dual-port on-chip memory with two Avalon-MM slave ports, A (narrow) and B (wide = RATIO_B × A), on a single clock.
- Successor to the fixed 32/64-bit OCM:
  - configurable width, depth, ratio and read latency;
  - readdatavalid/waitrequest handshakes;
  - deterministic write-collision resolution;
  - hardware clear sequencer that zeroises the array after reset or on request.
- Sits behind the Nios/DMA interconnect as shared probability/sample buffer.

Parameters:
DATA_W_A, 32, port A data width in bits (multiple of 8)
RATIO_B, 2, port B width multiplier (1, 2, 4 or 8)
DEPTH_A, 17920, words at port A width (multiple of RATIO_B)
READ_LATENCY, 1, cycles from accepted read to readdatavalid (1 or 2)
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset release
CLEAR_VALUE, 0, byte value written to every byte during clear

Derived values:
- DEPTH_B = DEPTH_A/RATIO_B
- AW_A = clog2(DEPTH_A), AW_B = clog2(DEPTH_B)
- BE_A = DATA_W_A/8, BE_B = BE_A*RATIO_B

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
a_address  in  AW_A  port A word address
a_byteenable  in  BE_A  port A byte enables
a_chipselect  in  1  port A select
a_read  in  1  port A read request
a_write  in  1  port A write request
a_writedata  in  DATA_W_A  port A write data
a_readdata  out  DATA_W_A  port A read data
a_readdatavalid  out  1  port A read data valid
a_waitrequest  out  1  port A stall
b_address  in  AW_B  port B word address
b_byteenable  in  BE_B  port B byte enables
b_chipselect  in  1  port B select
b_read  in  1  port B read request
b_write  in  1  port B write request
b_writedata  in  DATA_W_A*RATIO_B  port B write data
b_readdata  out  DATA_W_A*RATIO_B  port B read data
b_readdatavalid  out  1  port B read data valid
b_waitrequest  out  1  port B stall
clear_req  in  1  single-cycle pulse requesting array clear
init_done  out  1  high when array usable (state READY)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- While reset_n=0:
  - readdata=0, readdatavalid=0, waitrequest=1 (both ports), init_done=0;
  - clear counter=0, read pipeline flushed;
  - array contents are not reset.
- Storage: single array of DEPTH_B × (DATA_W_A·RATIO_B) bits.
  - Port A word n maps to B word n>>log2(RATIO_B), lane n mod RATIO_B (lane 0 = LSBs).
- FSM states: RESET → CLEAR or READY; CLEAR → READY; READY → CLEAR.
  - First cycle after reset_n rises: go to CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: write CLEAR_VALUE to all bytes of B word cnt; cnt increments each cycle.
  - CLEAR → READY after writing word DEPTH_B−1. Clear occupies exactly DEPTH_B cycles.
  - READY: init_done=1, waitrequest=0 on both ports.
  - clear_req=1 in READY → CLEAR next cycle; clear_req is ignored in CLEAR.
  - Reads already in the pipeline still complete with their readdatavalid; data for such reads is undefined.
- waitrequest=1 in RESET and CLEAR.
- Transfer acceptance: accepted when chipselect & (read|write) & ~waitrequest.
- Reads:
  - data is registered; readdatavalid pulses exactly READ_LATENCY cycles after the accept cycle;
  - back-to-back reads at one per cycle are supported;
  - readdata holds its last value when readdatavalid=0.
- Writes: complete in the accept cycle and are visible to any read accepted the following cycle.
- read & write in the same cycle on one port: both accepted; the read returns the pre-write data.
- Mixed-port read during write to the same word in the same cycle: the read returns old data.
- Collision, both ports writing overlapping bytes in the same cycle:
  - port B wins for each overlapping byte;
  - non-overlapping enabled bytes from both ports are written.
- Address wrap: out-of-range addresses (≥DEPTH) wrap modulo DEPTH; no error signalled.
- Reset mid-CLEAR: counter restarts at 0 after reset release; the clear fully restarts.

Test Plan:
Bench config: DEPTH_A=16, RATIO_B=2, DATA_W_A=32, READ_LATENCY=1.
- Release reset_n → waitrequest=1 for 8 cycles; init_done rises on cycle 9; B reads of words 0..7 return 0x0000000000000000.
- A write addr 3 = 0xDEADBEEF, BE=0xF → B read addr 1 next cycle returns 0xDEADBEEF_xxxxxxxx (upper lane); readdatavalid 1 cycle after accept.
- Same cycle: A write addr 4 = 0x11223344, BE=0x3, and B write addr 2 = 0xAAAAAAAA_55667788, BE=0x01 → A reads addr 4 as 0x00003388.
- B write word 5 = 0x0123456789ABCDEF, then clear_req pulse → waitrequest=1 for 8 cycles; word 5 subsequently reads 0.
- A read addr 6 accepted in the same cycle as B write to word 3 → A returns the old value.
- Then 4 consecutive A reads → 4 consecutive readdatavalid pulses.
- Assert reset_n=0 at clear cycle 4, release it → full 8-cycle clear observed again; no readdatavalid during reset.

Source files
------------

// File: rtl/ocm_dp_ram_ctrl.sv
// Dual-port on-chip RAM: narrow port A, wide port B (RATIO_B lanes), registered reads,
// byte-level write collision resolution (port B wins) and a hardware clear sequencer.
module ocm_dp_ram_ctrl #(
    parameter int DATA_W_A = 32,
    parameter int RATIO_B = 2,
    parameter int DEPTH_A = 17920,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [7:0] CLEAR_VALUE = 8'h00,
    localparam int DEPTH_B = DEPTH_A / RATIO_B,
    localparam int AW_A = $clog2(DEPTH_A),
    localparam int AW_B = $clog2(DEPTH_B),
    localparam int BE_A = DATA_W_A / 8,
    localparam int BE_B = BE_A * RATIO_B,
    localparam int DATA_W_B = DATA_W_A * RATIO_B
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [AW_A-1:0]     a_address,
    input  logic [BE_A-1:0]     a_byteenable,
    input  logic                a_chipselect,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W_A-1:0] a_writedata,
    output logic [DATA_W_A-1:0] a_readdata,
    output logic                a_readdatavalid,
    output logic                a_waitrequest,
    input  logic [AW_B-1:0]     b_address,
    input  logic [BE_B-1:0]     b_byteenable,
    input  logic                b_chipselect,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W_B-1:0] b_writedata,
    output logic [DATA_W_B-1:0] b_readdata,
    output logic                b_readdatavalid,
    output logic                b_waitrequest,
    input  logic                clear_req,
    output logic                init_done
);
    localparam int LANE_W = (RATIO_B > 1) ? $clog2(RATIO_B) : 1;

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t              state, state_next;
    logic [AW_B-1:0]     cnt, cnt_next;
    logic                clear_we;
    logic                ready;

    logic [DATA_W_B-1:0] mem [DEPTH_B];

    logic [AW_A-1:0]     a_addr_w;
    logic [AW_B-1:0]     a_word, b_word;
    logic [LANE_W-1:0]   a_lane;
    logic                a_rd_acc, a_wr_acc, b_rd_acc, b_wr_acc;
    logic [BE_B-1:0]     a_bmask;
    logic [DATA_W_B-1:0] a_wdata_w;
    logic [DATA_W_B-1:0] a_new, b_new;
    logic [DATA_W_A-1:0] a_rd_lane;
    logic [DATA_W_A-1:0] a_d1, a_d2;
    logic [DATA_W_B-1:0] b_d1, b_d2;
    logic                a_v1, a_v2, b_v1, b_v2;

    // Out-of-range addresses can exceed DEPTH by less than DEPTH, so one subtraction wraps them
    assign a_addr_w = (32'(a_address) >= DEPTH_A) ? AW_A'(32'(a_address) - DEPTH_A) : a_address;
    assign b_word   = (32'(b_address) >= DEPTH_B) ? AW_B'(32'(b_address) - DEPTH_B) : b_address;
    assign a_word   = AW_B'(32'(a_addr_w) / RATIO_B);
    assign a_lane   = LANE_W'(32'(a_addr_w) % RATIO_B);

    assign ready         = (state == ST_READY) && reset_n;
    assign init_done     = ready;
    assign a_waitrequest = ~ready;
    assign b_waitrequest = ~ready;

    assign a_rd_acc = ready && a_chipselect && a_read;
    assign a_wr_acc = ready && a_chipselect && a_write;
    assign b_rd_acc = ready && b_chipselect && b_read;
    assign b_wr_acc = ready && b_chipselect && b_write;

    assign a_bmask   = BE_B'(a_byteenable) << (32'(a_lane) * BE_A);
    assign a_wdata_w = DATA_W_B'(a_writedata) << (32'(a_lane) * DATA_W_A);
    assign a_rd_lane = DATA_W_A'(mem[a_word] >> (32'(a_lane) * DATA_W_A));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        clear_we   = 1'b0;
        case (state)
            ST_RESET: state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: begin
                clear_we = reset_n;
                cnt_next = cnt + 1'b1;
                if (32'(cnt) == DEPTH_B - 1) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end
            end
            ST_READY: if (clear_req) state_next = ST_CLEAR;
            default:  state_next = ST_RESET;
        endcase
    end

    // Both merged words carry the other port's bytes when they hit the same word, B applied last
    always_comb begin
        a_new = mem[a_word];
        b_new = mem[b_word];
        for (int j = 0; j < BE_B; j++) begin
            if (a_wr_acc && a_bmask[j]) begin
                a_new[j*8 +: 8] = a_wdata_w[j*8 +: 8];
                if (a_word == b_word) b_new[j*8 +: 8] = a_wdata_w[j*8 +: 8];
            end
        end
        for (int j = 0; j < BE_B; j++) begin
            if (b_wr_acc && b_byteenable[j]) begin
                b_new[j*8 +: 8] = b_writedata[j*8 +: 8];
                if (a_word == b_word) a_new[j*8 +: 8] = b_writedata[j*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear_we) mem[cnt] <= {BE_B{CLEAR_VALUE}};
        if (a_wr_acc) mem[a_word] <= a_new;
        if (b_wr_acc) mem[b_word] <= b_new;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_d1 <= '0;
            a_d2 <= '0;
            b_d1 <= '0;
            b_d2 <= '0;
            a_v1 <= 1'b0;
            a_v2 <= 1'b0;
            b_v1 <= 1'b0;
            b_v2 <= 1'b0;
        end else begin
            a_v1 <= a_rd_acc;
            b_v1 <= b_rd_acc;
            a_v2 <= a_v1;
            b_v2 <= b_v1;
            if (a_rd_acc) a_d1 <= a_rd_lane;
            if (b_rd_acc) b_d1 <= mem[b_word];
            if (a_v1) a_d2 <= a_d1;
            if (b_v1) b_d2 <= b_d1;
        end
    end

    assign a_readdata      = (READ_LATENCY == 2) ? a_d2 : a_d1;
    assign a_readdatavalid = (READ_LATENCY == 2) ? a_v2 : a_v1;
    assign b_readdata      = (READ_LATENCY == 2) ? b_d2 : b_d1;
    assign b_readdatavalid = (READ_LATENCY == 2) ? b_v2 : b_v1;

endmodule

// File: tb/tb_ocm_dp_ram_ctrl.sv
// Directed bench for ocm_dp_ram_ctrl: a reference memory model predicts read data and
// a per-port scoreboard matches each readdatavalid pulse against the expected data and cycle.
module tb_ocm_dp_ram_ctrl;
    localparam int RL = 1;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  a_address;
    logic [3:0]  a_byteenable;
    logic        a_chipselect, a_read, a_write;
    logic [31:0] a_writedata;
    logic [31:0] a_readdata;
    logic        a_readdatavalid, a_waitrequest;
    logic [2:0]  b_address;
    logic [7:0]  b_byteenable;
    logic        b_chipselect, b_read, b_write;
    logic [63:0] b_writedata;
    logic [63:0] b_readdata;
    logic        b_readdatavalid, b_waitrequest;
    logic        clear_req;
    logic        init_done;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [63:0] model [8];
    exp_t        a_q[$];
    exp_t        b_q[$];

    ocm_dp_ram_ctrl #(
        .DATA_W_A(32), .RATIO_B(2), .DEPTH_A(16), .READ_LATENCY(RL),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid), .a_waitrequest(a_waitrequest),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
        .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid), .b_waitrequest(b_waitrequest),
        .clear_req(clear_req), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = 64'h0;
    endtask

    // Drives one cycle of port traffic; expected read data comes from the model before its writes
    task automatic applyStimulus(
        input logic ar, input logic aw, input logic [3:0] aadr, input logic [3:0] abe,
        input logic [31:0] awd,
        input logic br, input logic bw, input logic [2:0] badr, input logic [7:0] bbe,
        input logic [63:0] bwd);
        exp_t e;
        int   wa;
        int   lane;
        wa   = int'(aadr >> 1);
        lane = int'(aadr[0]);
        a_chipselect = ar | aw;
        a_read       = ar;
        a_write      = aw;
        a_address    = aadr;
        a_byteenable = abe;
        a_writedata  = awd;
        b_chipselect = br | bw;
        b_read       = br;
        b_write      = bw;
        b_address    = badr;
        b_byteenable = bbe;
        b_writedata  = bwd;
        if (ar) begin
            e.data = (lane == 1) ? {32'h0, model[wa][63:32]} : {32'h0, model[wa][31:0]};
            e.due  = cyc + RL;
            a_q.push_back(e);
        end
        if (br) begin
            e.data = model[badr];
            e.due  = cyc + RL;
            b_q.push_back(e);
        end
        for (int i = 0; i < 4; i++)
            if (aw && abe[i]) model[wa][lane*32 + i*8 +: 8] = awd[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            if (bw && bbe[i]) model[badr][i*8 +: 8] = bwd[i*8 +: 8];
        tick();
        a_chipselect = 1'b0;
        a_read       = 1'b0;
        a_write      = 1'b0;
        b_chipselect = 1'b0;
        b_read       = 1'b0;
        b_write      = 1'b0;
    endtask

    task automatic check_clear_window(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            checkOutput({tag, "_a_wait"}, 64'(a_waitrequest), 64'h1);
            checkOutput({tag, "_b_wait"}, 64'(b_waitrequest), 64'h1);
        end
        tick();
        checkOutput({tag, "_init_done"}, 64'(init_done), 64'h1);
        checkOutput({tag, "_a_wait_low"}, 64'(a_waitrequest), 64'h0);
        checkOutput({tag, "_b_wait_low"}, 64'(b_waitrequest), 64'h0);
    endtask

    // Scoreboard: every valid pulse pops one expectation; data and arrival cycle must match
    always @(negedge clk) begin
        exp_t ea;
        exp_t eb;
        if (a_q.size() > 0 && a_q[0].due < cyc) begin
            ea = a_q.pop_front();
            total++;
            bad++;
            $error("[TB] FAIL a_missing_valid observed=none expected=valid_at_cycle_%0d", ea.due);
        end
        if (b_q.size() > 0 && b_q[0].due < cyc) begin
            eb = b_q.pop_front();
            total++;
            bad++;
            $error("[TB] FAIL b_missing_valid observed=none expected=valid_at_cycle_%0d", eb.due);
        end
        if (a_readdatavalid === 1'b1) begin
            if (a_q.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL a_unexpected_valid observed=1 expected=0 cycle=%0d", cyc);
            end else begin
                ea = a_q.pop_front();
                checkOutput("a_rdata", 64'(a_readdata), ea.data);
                checkOutput("a_latency", 64'(cyc), 64'(ea.due));
            end
        end
        if (b_readdatavalid === 1'b1) begin
            if (b_q.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL b_unexpected_valid observed=1 expected=0 cycle=%0d", cyc);
            end else begin
                eb = b_q.pop_front();
                checkOutput("b_rdata", b_readdata, eb.data);
                checkOutput("b_latency", 64'(cyc), 64'(eb.due));
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        clear_req    = 1'b0;
        a_chipselect = 1'b0;
        a_read       = 1'b0;
        a_write      = 1'b0;
        a_address    = '0;
        a_byteenable = '0;
        a_writedata  = '0;
        b_chipselect = 1'b0;
        b_read       = 1'b0;
        b_write      = 1'b0;
        b_address    = '0;
        b_byteenable = '0;
        b_writedata  = '0;
        model_clear();

        repeat (3) tick();
        checkOutput("rst_a_wait", 64'(a_waitrequest), 64'h1);
        checkOutput("rst_b_wait", 64'(b_waitrequest), 64'h1);
        checkOutput("rst_init_done", 64'(init_done), 64'h0);
        checkOutput("rst_a_valid", 64'(a_readdatavalid), 64'h0);
        checkOutput("rst_b_valid", 64'(b_readdatavalid), 64'h0);
        checkOutput("rst_a_rdata", 64'(a_readdata), 64'h0);
        checkOutput("rst_b_rdata", b_readdata, 64'h0);

        reset_n = 1'b1;
        tick();
        check_clear_window("init_clr");

        for (int w = 0; w < 8; w++)
            applyStimulus(0, 0, 4'd0, 4'h0, 32'h0, 1, 0, 3'(w), 8'h00, 64'h0);

        applyStimulus(1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 1'b0, 3'd1, 8'h00, 64'h0);

        applyStimulus(1'b0, 1'b1, 4'd4, 4'h3, 32'h11223344,
                      1'b0, 1'b1, 3'd2, 8'h01, 64'hAAAAAAAA_55667788);
        applyStimulus(1'b1, 1'b0, 4'd4, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);

        applyStimulus(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 1'b1, 3'd6, 8'hF0, 64'hFFEEDDCC_BBAA9988);
        applyStimulus(1'b1, 1'b0, 4'd13, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd12, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);

        applyStimulus(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 1'b1, 3'd5, 8'hFF, 64'h01234567_89ABCDEF);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 1'b0, 3'd5, 8'h00, 64'h0);
        tick();

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        model_clear();
        check_clear_window("req_clr");
        applyStimulus(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b1, 1'b0, 3'd5, 8'h00, 64'h0);

        applyStimulus(1'b0, 1'b1, 4'd6, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd6, 4'h0, 32'h0, 1'b0, 1'b1, 3'd3, 8'hFF, 64'h11111111_22222222);

        applyStimulus(1'b1, 1'b0, 4'd4, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd6, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        tick();
        checkOutput("a_hold", 64'(a_readdata), 64'h22222222);
        checkOutput("a_valid_low", 64'(a_readdatavalid), 64'h0);

        applyStimulus(1'b1, 1'b1, 4'd7, 4'hF, 32'h77777777, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b1, 1'b0, 3'd3, 8'h00, 64'h0);
        tick();

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        checkOutput("midclr_a_wait", 64'(a_waitrequest), 64'h1);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("midrst_a_valid", 64'(a_readdatavalid), 64'h0);
            checkOutput("midrst_b_valid", 64'(b_readdatavalid), 64'h0);
            checkOutput("midrst_init_done", 64'(init_done), 64'h0);
            checkOutput("midrst_b_wait", 64'(b_waitrequest), 64'h1);
            checkOutput("midrst_a_rdata", 64'(a_readdata), 64'h0);
        end
        reset_n = 1'b1;
        model_clear();
        tick();
        check_clear_window("reclr");
        applyStimulus(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b1, 1'b0, 3'd3, 8'h00, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'd13, 4'h0, 32'h0, 1'b1, 1'b0, 3'd2, 8'h00, 64'h0);

        repeat (3) tick();
        checkOutput("a_q_empty", 64'(a_q.size()), 64'h0);
        checkOutput("b_q_empty", 64'(b_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
